// File: rtl/seg7_pkg.sv
// Shared definitions for the 6-digit multiplexed 7-segment display blocks:
// segment pattern table, digit count and receiver FSM states.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned WORD_W     = 4 * NUM_DIGITS;
    localparam logic [2:0]  LAST_SEL   = 3'(NUM_DIGITS - 1);

    // Idle pin value: all segments and dp off (active-low).
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;

    // Active-low g..a patterns, entry i shows hex digit i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        HUNT,
        COLLECT
    } rx_state_e;

endpackage

// File: rtl/seg7_scan_rx_if.sv
// Scanned display lines plus the decoded-frame and error outputs of the receiver.
interface seg7_scan_rx_if;
    import seg7_pkg::*;

    logic [2:0]        sel;
    logic [7:0]        seg;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              seg_err;
    logic              seq_err;
    logic              timeout_err;

    modport master (
        output sel, seg,
        input  data_out, data_valid, seg_err, seq_err, timeout_err
    );

    modport slave (
        input  sel, seg,
        output data_out, data_valid, seg_err, seq_err, timeout_err
    );

endinterface

// File: rtl/seg7_pattern_dec.sv
// Combinational reverse lookup of an active-low 7-segment pattern to its hex nibble;
// bad_o flags a pattern that is not in the table.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       bad_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        nibble_o = '0;
        bad_o    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_TABLE[i]) begin
                nibble_o = 4'(i);
                bad_o    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// Receive side of the 6-digit scan driver: waits for each digit to settle, decodes it,
// and assembles sel 0..5 into a 24-bit word with sequence, pattern and timeout errors.
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 16,
    parameter int unsigned TIMEOUT     = 200_000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg7_scan_rx_if.slave bus
);

    localparam int unsigned IN_W   = 11;
    localparam int unsigned CHAIN  = (SYNC_STAGES == 0) ? 1 : SYNC_STAGES;
    localparam int unsigned STAB_W = $clog2(SETTLE + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [IN_W-1:0]   IN_RST    = {3'd0, SEG_BLANK};
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(SETTLE);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    // pipe[0] is the raw pin value, pipe[i+1] the i-th flop behind it.
    logic [CHAIN-1:0][IN_W-1:0] chain_q;
    logic [CHAIN:0][IN_W-1:0]   pipe;
    logic [IN_W-1:0]            cmp_new, cmp_old;
    logic [2:0]                 s_sel;
    logic [6:0]                 s_seg;

    assign pipe = {chain_q, {bus.sel, bus.seg}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_q <= {CHAIN{IN_RST}};
        else        chain_q <= pipe[CHAIN-1:0];
    end

    // With a synchroniser the change is seen one stage early, so the settle count
    // restarts on the same edge the synchronised value moves.
    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign cmp_new = pipe[0];
            assign cmp_old = pipe[1];
            assign s_sel   = pipe[0][10:8];
            assign s_seg   = pipe[0][6:0];
        end else begin : g_sync
            assign cmp_new = pipe[SYNC_STAGES-1];
            assign cmp_old = pipe[SYNC_STAGES];
            assign s_sel   = pipe[SYNC_STAGES][10:8];
            assign s_seg   = pipe[SYNC_STAGES][6:0];
        end
    endgenerate

    logic       changed, sel_changed, bad;
    logic [3:0] nibble;

    assign changed     = (cmp_new != cmp_old);
    assign sel_changed = (cmp_new[10:8] != cmp_old[10:8]);

    seg7_pattern_dec u_dec (
        .seg_i    (s_seg),
        .nibble_o (nibble),
        .bad_o    (bad)
    );

    logic [STAB_W-1:0] stab_q, stab_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              sample, tmo_expire;
    rx_state_e         state_q, state_d;

    always_comb begin
        stab_d = stab_q;
        if (changed)                stab_d = '0;
        else if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;

        tmo_d = '0;
        if (state_q == COLLECT && !sel_changed)
            tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    end

    assign sample     = !changed && (stab_q == STAB_LAST);
    assign tmo_expire = (state_q == COLLECT) && !sel_changed && (tmo_q >= TMO_LAST);

    logic [2:0]        exp_q, exp_d;
    logic [WORD_W-1:0] shadow_q, shadow_d, data_out_q, data_out_d;
    logic              valid_q, valid_d, seg_err_q, seg_err_d;
    logic              seq_err_q, seq_err_d, tmo_err_q, tmo_err_d;

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        shadow_d   = shadow_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        seg_err_d  = 1'b0;
        seq_err_d  = 1'b0;
        tmo_err_d  = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (sample) begin
                    if (s_sel == 3'd0 && !bad) begin
                        shadow_d[WORD_W-1 -: 4] = nibble;
                        exp_d   = 3'd1;
                        state_d = COLLECT;
                    end else begin
                        seg_err_d = bad;
                    end
                end
            end
            COLLECT: begin
                if (sample) begin
                    if (bad) begin
                        seg_err_d = 1'b1;
                        state_d   = HUNT;
                    end else if (s_sel != exp_q) begin
                        // A stray sel=0 is taken as the start of a new frame.
                        seq_err_d = 1'b1;
                        if (s_sel == 3'd0) begin
                            shadow_d[WORD_W-1 -: 4] = nibble;
                            exp_d = 3'd1;
                        end else begin
                            state_d = HUNT;
                        end
                    end else if (exp_q != LAST_SEL) begin
                        shadow_d[4*(int'(LAST_SEL) - int'(exp_q)) +: 4] = nibble;
                        exp_d = exp_q + 1'b1;
                    end else begin
                        data_out_d = {shadow_q[WORD_W-1:4], nibble};
                        valid_d    = 1'b1;
                        state_d    = HUNT;
                    end
                end else if (tmo_expire) begin
                    tmo_err_d = 1'b1;
                    state_d   = HUNT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            exp_q      <= '0;
            shadow_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            seg_err_q  <= 1'b0;
            seq_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            stab_q     <= '0;
            tmo_q      <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            exp_q      <= exp_d;
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            seg_err_q  <= seg_err_d;
            seq_err_q  <= seq_err_d;
            tmo_err_q  <= tmo_err_d;
            stab_q     <= stab_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = valid_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed bench for seg7_scan_rx: scans hand-picked words through the pins and checks
// decoded frames, pulse counts, latencies and error reporting.
module tb_seg7_scan_rx;

    localparam int SYNC    = 2;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    localparam int HOLD    = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_rx_if bus ();

    seg7_scan_rx #(
        .SYNC_STAGES (SYNC),
        .SETTLE      (SETTLE),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Independent copy of the g..a patterns for digits 0..F.
    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [7:0] enc(input logic [3:0] n);
        return {1'b1, pat[n]};
    endfunction

    int cyc = 0;
    int dv_n = 0, se_n = 0, qe_n = 0, to_n = 0;
    int dv_at = 0, qe_at = 0, to_at = 0;
    int chg_cyc = 0;
    int dv0, se0, qe0, to0;
    int vectors = 0, miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid  === 1'b1) begin dv_n <= dv_n + 1; dv_at <= cyc; end
        if (bus.seg_err     === 1'b1) se_n <= se_n + 1;
        if (bus.seq_err     === 1'b1) begin qe_n <= qe_n + 1; qe_at <= cyc; end
        if (bus.timeout_err === 1'b1) begin to_n <= to_n + 1; to_at <= cyc; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        dv0 = dv_n; se0 = se_n; qe0 = qe_n; to0 = to_n;
    endtask

    task automatic drive_digit(input logic [2:0] s, input logic [7:0] g, input int n);
        @(posedge clk);
        #1;
        bus.sel = s;
        bus.seg = g;
        chg_cyc = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic drive_frame(input logic [23:0] word, input bit glitch);
        logic [3:0] nib;
        for (int k = 0; k < 6; k++) begin
            nib = word[23 - 4*k -: 4];
            if (glitch) begin
                drive_digit(3'(k), ~enc(nib), 2);
                drive_digit(3'(k), enc(nib), HOLD - 2);
            end else begin
                drive_digit(3'(k), enc(nib), HOLD);
            end
        end
    endtask

    initial begin
        bus.sel = 3'd5;
        bus.seg = enc(4'h0);
        repeat (3) step();
        check("reset data_out", bus.data_out, 0);
        check("reset data_valid", bus.data_valid, 0);
        check("reset seg_err", bus.seg_err, 0);
        check("reset seq_err", bus.seq_err, 0);
        check("reset timeout_err", bus.timeout_err, 0);
        rst_n = 1'b1;
        repeat (10) step();

        // 1: clean frame, data_valid SYNC+SETTLE cycles after the sel=5 pin change
        snap();
        drive_frame(24'h123456, 1'b0);
        step();
        check("t1 data_valid count", dv_n - dv0, 1);
        check("t1 data_valid latency", dv_at - chg_cyc, SYNC + SETTLE);
        check("t1 data_out", bus.data_out, 24'h123456);
        check("t1 seg_err count", se_n - se0, 0);
        check("t1 seq_err count", qe_n - qe0, 0);
        check("t1 timeout count", to_n - to0, 0);

        // 2: reset, then join the scan mid-frame at sel=3
        rst_n = 1'b0;
        #1;
        check("t2 async reset data_out", bus.data_out, 0);
        step();
        rst_n = 1'b1;
        snap();
        drive_digit(3'd3, enc(4'hD), HOLD);
        drive_digit(3'd4, enc(4'hE), HOLD);
        drive_digit(3'd5, enc(4'hF), HOLD);
        step();
        check("t2 partial ignored", dv_n - dv0, 0);
        drive_frame(24'hABCDEF, 1'b0);
        step();
        check("t2 data_valid count", dv_n - dv0, 1);
        check("t2 data_out", bus.data_out, 24'hABCDEF);
        check("t2 seq_err count", qe_n - qe0, 0);
        check("t2 seg_err count", se_n - se0, 0);

        // 4: unrecognised pattern at sel=2 discards the frame
        snap();
        drive_digit(3'd0, enc(4'h1), HOLD);
        drive_digit(3'd1, enc(4'h2), HOLD);
        drive_digit(3'd2, 8'hFF, HOLD);
        drive_digit(3'd3, enc(4'h4), HOLD);
        drive_digit(3'd4, enc(4'h5), HOLD);
        drive_digit(3'd5, enc(4'h6), HOLD);
        step();
        check("t4 seg_err count", se_n - se0, 1);
        check("t4 data_valid count", dv_n - dv0, 0);
        check("t4 seq_err count", qe_n - qe0, 0);
        check("t4 data_out held", bus.data_out, 24'hABCDEF);

        // 3: skipped digit 0,1,2,4 then a clean all-zero frame
        snap();
        drive_digit(3'd0, enc(4'h0), HOLD);
        drive_digit(3'd1, enc(4'h0), HOLD);
        drive_digit(3'd2, enc(4'h0), HOLD);
        drive_digit(3'd4, enc(4'h0), HOLD);
        step();
        check("t3 seq_err count", qe_n - qe0, 1);
        check("t3 seq_err latency", qe_at - chg_cyc, SYNC + SETTLE);
        check("t3 no data_valid", dv_n - dv0, 0);
        drive_frame(24'h000000, 1'b0);
        step();
        check("t3 zero frame valid", dv_n - dv0, 1);
        check("t3 zero frame data", bus.data_out, 24'h000000);

        // 3b: sel=0 out of order restarts the frame but still flags seq_err
        snap();
        drive_digit(3'd0, enc(4'h3), HOLD);
        drive_digit(3'd1, enc(4'h3), HOLD);
        drive_digit(3'd0, enc(4'h5), HOLD);
        drive_digit(3'd1, enc(4'hA), HOLD);
        drive_digit(3'd2, enc(4'h5), HOLD);
        drive_digit(3'd3, enc(4'hA), HOLD);
        drive_digit(3'd4, enc(4'h5), HOLD);
        drive_digit(3'd5, enc(4'hA), HOLD);
        step();
        check("t3b seq_err count", qe_n - qe0, 1);
        check("t3b data_valid count", dv_n - dv0, 1);
        check("t3b data_out", bus.data_out, 24'h5A5A5A);
        check("t3b seg_err count", se_n - se0, 0);

        // 5: short glitches at every digit, then a stalled scan
        snap();
        drive_frame(24'h789BCD, 1'b1);
        step();
        check("t5 glitch data_valid", dv_n - dv0, 1);
        check("t5 glitch data_out", bus.data_out, 24'h789BCD);
        check("t5 glitch seg_err", se_n - se0, 0);
        check("t5 glitch seq_err", qe_n - qe0, 0);
        check("t5 glitch timeout", to_n - to0, 0);
        snap();
        drive_digit(3'd0, enc(4'h0), HOLD);
        drive_digit(3'd1, enc(4'h1), 100);
        step();
        check("t5 timeout count", to_n - to0, 1);
        // TIMEOUT cycles after the synchronised sel change, plus the synchroniser.
        check("t5 timeout latency", to_at - chg_cyc, SYNC + TIMEOUT);
        check("t5 stall no data_valid", dv_n - dv0, 0);
        drive_digit(3'd2, enc(4'h2), HOLD);
        drive_digit(3'd3, enc(4'h3), HOLD);
        drive_digit(3'd4, enc(4'h4), HOLD);
        drive_digit(3'd5, enc(4'h5), HOLD);
        step();
        check("t5 hunt no seq_err", qe_n - qe0, 0);
        check("t5 hunt no data_valid", dv_n - dv0, 0);
        check("t5 data_out held", bus.data_out, 24'h789BCD);

        // 6: reset mid-frame at sel=3
        drive_digit(3'd0, enc(4'h2), HOLD);
        drive_digit(3'd1, enc(4'h4), HOLD);
        drive_digit(3'd2, enc(4'h6), HOLD);
        drive_digit(3'd3, enc(4'h8), 10);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6 async reset data_out", bus.data_out, 0);
        check("t6 async reset flags",
              {bus.data_valid, bus.seg_err, bus.seq_err, bus.timeout_err}, 0);
        step();
        step();
        rst_n = 1'b1;
        snap();
        drive_frame(24'h2468AC, 1'b0);
        step();
        check("t6 data_valid count", dv_n - dv0, 1);
        check("t6 data_out", bus.data_out, 24'h2468AC);
        check("t6 error count", (se_n - se0) + (qe_n - qe0) + (to_n - to0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
